arb_mux_n: RTL

ARB_MUX_N -- requirements
Module: arb_mux_n

---
 rtl/arb_mux_n.sv | 134 +++++++++++++
 1 files changed

// File: rtl/arb_mux_n.sv
// N:1 arbitrating multiplexer with burst locking (round-robin or fixed priority)
// feeding a single registered output stage with valid/ready flow control.
module arb_mux_n #(
    parameter int unsigned NUM_CH     = 8,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned SEL_WIDTH  = 3,
    parameter int unsigned ARB_MODE   = 0
) (
    input  logic                         Clk,
    input  logic                         Reset_n,
    input  logic [NUM_CH-1:0]            InValid,
    input  logic [NUM_CH*DATA_WIDTH-1:0] InData,
    input  logic [NUM_CH-1:0]            InLast,
    output logic [NUM_CH-1:0]            InReady,
    output logic                         OutValid,
    output logic [DATA_WIDTH-1:0]        OutData,
    output logic [SEL_WIDTH-1:0]         OutCh,
    output logic                         OutLast,
    input  logic                         OutReady
);

    typedef enum logic [0:0] {StIdle, StBurst} state_e;

    state_e                  state_q, state_d;
    logic [SEL_WIDTH-1:0]    grant_q, grant_d;
    logic [SEL_WIDTH-1:0]    rr_ptr_q, rr_ptr_d;
    logic                    out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic [SEL_WIDTH-1:0]    out_ch_q, out_ch_d;
    logic                    out_last_q, out_last_d;

    logic                    space;
    logic                    found;
    logic [SEL_WIDTH-1:0]    winner;
    logic [SEL_WIDTH-1:0]    sel_ch;
    logic [NUM_CH-1:0]       valid_shift;
    logic [NUM_CH-1:0]       last_shift;
    logic [NUM_CH*DATA_WIDTH-1:0] data_shift;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic                    sel_last;
    logic                    accept;
    int unsigned             idx;

    assign space = !out_valid_q || OutReady;

    // Search order starts at the round-robin pointer (mode 0) or at channel 0 (mode 1).
    always_comb begin : arbitrate
        found       = 1'b0;
        winner      = '0;
        idx         = 0;
        valid_shift = '0;
        for (int k = 0; k < int'(NUM_CH); k++) begin
            if (ARB_MODE == 0) begin
                idx = (32'(rr_ptr_q) + 32'(k)) % NUM_CH;
            end else begin
                idx = 32'(k);
            end
            valid_shift = InValid >> idx;
            if (!found && valid_shift[0]) begin
                found  = 1'b1;
                winner = SEL_WIDTH'(idx);
            end
        end
    end

    assign sel_ch = (state_q == StBurst) ? grant_q : winner;

    always_comb begin : ready_gen
        InReady = '0;
        if (Reset_n && space && ((state_q == StBurst) || found)) begin
            InReady = NUM_CH'(1) << sel_ch;
        end
    end

    always_comb begin : select
        last_shift = InLast >> sel_ch;
        data_shift = InData >> (32'(sel_ch) * DATA_WIDTH);
        sel_last   = last_shift[0];
        sel_data   = data_shift[DATA_WIDTH-1:0];
    end

    assign accept = |(InValid & InReady);

    always_comb begin : next_state
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_last_d  = out_last_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_ch_d    = sel_ch;
            out_last_d  = sel_last;
            if (sel_last) begin
                state_d  = StIdle;
                rr_ptr_d = (32'(sel_ch) == NUM_CH - 1) ? '0 : sel_ch + SEL_WIDTH'(1);
            end else begin
                state_d = StBurst;
                grant_d = sel_ch;
            end
        end else if (OutReady) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_last_q  <= out_last_d;
        end
    end

    assign OutValid = out_valid_q;
    assign OutData  = out_data_q;
    assign OutCh    = out_ch_q;
    assign OutLast  = out_last_q;

endmodule
